// File: rtl/direction_input_ctrl.sv
// Turns four raw push-buttons into paced one-hot direction commands for game2048.
// Optional auto-repeat while a button is held is enabled with `define DIR_REPEAT_EN.
module direction_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic [1:0]  game_state,
   output logic [3:0]  direction,
   output logic [15:0] move_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("direction_input_ctrl: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_RELEASE} state_t;

   // Bit order matches the direction encoding: up, down, left, right.
   logic [3:0]    raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    db;
   logic [3:0]    db_prev;
   logic [CW-1:0] cnt [4];
   logic [3:0]    press;
   logic [3:0]    pick;
   logic [3:0]    code;
   logic          playing;
   state_t        state;

   assign raw     = {btn_right, btn_left, btn_down, btn_up};
   assign playing = (game_state == 2'b01);
   assign press   = db & ~db_prev;

   always_ff @(posedge clk) begin
      sync1 <= raw;
      sync2 <= sync1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db      <= '0;
         db_prev <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         db_prev <= db;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               db[i]  <= ~db[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      pick = 4'b0000;
      if (press[0])      pick = 4'b0001;
      else if (press[1]) pick = 4'b0010;
      else if (press[2]) pick = 4'b0100;
      else if (press[3]) pick = 4'b1000;
   end

`ifdef DIR_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rpt_cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_WAIT;
         direction  <= '0;
         code       <= '0;
         move_count <= '0;
`ifdef DIR_REPEAT_EN
         rpt_cnt    <= '0;
`endif
      end else begin
         case (state)
            S_WAIT: begin
               if (|press && playing) begin
                  code      <= pick;
                  direction <= pick;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Leaving "playing" means the game consumed the move (or ended).
               if (!playing) begin
                  direction  <= '0;
                  move_count <= move_count + 16'd1;
                  state      <= S_RELEASE;
`ifdef DIR_REPEAT_EN
                  rpt_cnt    <= '0;
`endif
               end
            end
            S_RELEASE: begin
`ifdef DIR_REPEAT_EN
               if (db == 4'b0000) begin
                  state   <= S_WAIT;
                  rpt_cnt <= '0;
               end else if (|(db & code) && playing) begin
                  if (rpt_cnt == RPT_LAST) begin
                     rpt_cnt   <= '0;
                     direction <= code;
                     state     <= S_ISSUE;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
               end else begin
                  rpt_cnt <= '0;
               end
`else
               if (db == 4'b0000) state <= S_WAIT;
`endif
            end
            default: begin
               state     <= S_WAIT;
               direction <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed bench for direction_input_ctrl with cycle-stamped expectations checked by a monitor.
module tb_direction_input_ctrl;

   logic        clk;
   logic        rst;
   logic        btn_up;
   logic        btn_down;
   logic        btn_left;
   logic        btn_right;
   logic [1:0]  game_state;
   logic [3:0]  direction;
   logic [15:0] move_count;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          at;
      logic [3:0]  dir;
      logic [15:0] mc;
      string       name;
   } exp_t;

   exp_t q[$];

   direction_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_CYCLES(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .game_state(game_state),
      .direction(direction),
      .move_count(move_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: at each falling edge compare every expectation stamped for this cycle.
   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < q.size()) begin
         if (q[i].at == cyc) begin
            checks++;
            if (direction !== q[i].dir) begin
               errors++;
               $display("FAIL %s cycle %0d: direction=%b expected=%b", q[i].name, cyc, direction, q[i].dir);
            end
            checks++;
            if (move_count !== q[i].mc) begin
               errors++;
               $display("FAIL %s cycle %0d: move_count=%0d expected=%0d", q[i].name, cyc, move_count, q[i].mc);
            end
            q.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expect the given outputs after k more rising edges.
   task automatic exp_at(input int k, input logic [3:0] d, input logic [15:0] m, input string nm);
      exp_t e;
      e.at   = cyc + k;
      e.dir  = d;
      e.mc   = m;
      e.name = nm;
      q.push_back(e);
   endtask

   initial begin
      rst        = 1'b1;
      btn_up     = 1'b1;
      btn_down   = 1'b1;
      btn_left   = 1'b1;
      btn_right  = 1'b1;
      game_state = 2'b01;

      // Reset held two cycles with every button high.
      @(negedge clk);
      exp_at(1, 4'b0000, 16'd0, "reset_state");
      tick(1);
      rst = 1'b0;
      exp_at(4, 4'b0000, 16'd0, "reset_hold");
      exp_at(5, 4'b0001, 16'd0, "reset_press");
      tick(5);
      game_state = 2'b00;
      exp_at(1, 4'b0000, 16'd1, "reset_accept");
      tick(1);
      game_state = 2'b01;
      {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      tick(10);

      // Clean press of left.
      btn_left = 1'b1;
      exp_at(6, 4'b0000, 16'd1, "left_early");
      exp_at(7, 4'b0100, 16'd1, "left_dir");
      tick(8);
      game_state = 2'b00;
      exp_at(1, 4'b0000, 16'd2, "left_clear");
      tick(2);
      game_state = 2'b01;
      exp_at(3, 4'b0000, 16'd2, "left_held_a");
      exp_at(7, 4'b0000, 16'd2, "left_held_b");
      tick(8);
      btn_left = 1'b0;
      tick(10);

      // Bouncing up button: 3 high / 2 low, ten times.
      for (int k = 3; k <= 55; k += 4) exp_at(k, 4'b0000, 16'd2, "bounce");
      for (int r = 0; r < 10; r++) begin
         btn_up = 1'b1;
         tick(3);
         btn_up = 1'b0;
         tick(2);
      end
      tick(10);

      // Simultaneous up and right: up wins.
      btn_up    = 1'b1;
      btn_right = 1'b1;
      exp_at(7, 4'b0001, 16'd2, "simul_dir");
      tick(8);
      game_state = 2'b00;
      exp_at(1, 4'b0000, 16'd3, "simul_clear");
      tick(2);
      game_state = 2'b01;
      btn_up    = 1'b0;
      btn_right = 1'b0;
      tick(10);

      // Press while the game is lost is discarded, and the held button stays silent.
      game_state = 2'b11;
      btn_down   = 1'b1;
      exp_at(7, 4'b0000, 16'd3, "np_dir");
      exp_at(10, 4'b0000, 16'd3, "np_dir_late");
      tick(10);
      game_state = 2'b01;
      exp_at(5, 4'b0000, 16'd3, "np_held");
      tick(8);
      btn_down = 1'b0;
      tick(6);
      btn_down = 1'b1;
      exp_at(7, 4'b0010, 16'd3, "np_press");
      tick(8);
      game_state = 2'b00;
      exp_at(1, 4'b0000, 16'd4, "np_clear");
      tick(2);
      game_state = 2'b01;
      btn_down = 1'b0;
      tick(10);

      // Right held past the accept.
      btn_right = 1'b1;
      exp_at(7, 4'b1000, 16'd4, "rpt_first");
      tick(8);
      game_state = 2'b00;
      exp_at(1, 4'b0000, 16'd5, "rpt_accept");
      tick(1);
      game_state = 2'b01;
`ifdef DIR_REPEAT_EN
      exp_at(19, 4'b0000, 16'd5, "rpt_wait");
      exp_at(20, 4'b1000, 16'd5, "rpt_again");
      tick(21);
      game_state = 2'b00;
      exp_at(1, 4'b0000, 16'd6, "rpt_second_accept");
      tick(2);
`else
      exp_at(20, 4'b0000, 16'd5, "norpt_idle_a");
      exp_at(30, 4'b0000, 16'd5, "norpt_idle_b");
      tick(31);
`endif
      btn_right = 1'b0;
      tick(5);

      if (q.size() != 0) begin
         errors += q.size();
         checks += q.size();
         $display("FAIL pending_checks: %0d expectations never reached, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/direction_input_ctrl.md
# direction_input_ctrl

Converts the four raw push-button inputs into the one-hot `direction` command consumed by `game2048`, and paces commands against `game_state`. Each button is synchronized and debounced, and only press edges are used. A command is issued only while the game reports playing. It is held until the game leaves the playing state, then cleared, and the button must be released before the next command is accepted. The block sits between the board pins and the `direction` input of `game2048`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronized input must differ from its debounced value before that value flips (10 ms at 50 MHz). Must be ≥1.
- `REPEAT_CYCLES`, default 25000000: auto-repeat hold interval. Used only with `DIR_REPEAT_EN`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `btn_up` in 1: raw, asynchronous, active-high.
- `btn_down` in 1: raw, asynchronous, active-high.
- `btn_left` in 1: raw, asynchronous, active-high.
- `btn_right` in 1: raw, asynchronous, active-high.
- `game_state` in 2: 00 not_playing, 01 playing, 10 win, 11 lose.
- `direction` out 4: one-hot command, registered. 0001 top, 0010 bottom, 0100 left, 1000 right. 0000 means no command.
- `move_count` out 16: number of accepted commands, registered.

## Operation
- **Synchronizer:** two flops per button. Neither flop is reset.
- **Debounce, per button:**
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever the synchronized value equals the debounced value.
  - Otherwise it increments. When it would reach DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
- **Press event:** debounced value rising (current 1, previous 0).
- **Priority:** when several press events occur in the same cycle, up > down > left > right.
- **FSM states:** WAIT, ISSUE, RELEASE. Reset state is WAIT.
  - **WAIT:** `direction`=0.
    - Press event and `game_state`==01: latch the one-hot code and go to ISSUE.
    - Press events in any other `game_state` are discarded; there is no queue.
  - **ISSUE:** `direction` = latched code.
    - When `game_state`!=01 (the game accepted the command, or the game ended): increment `move_count` and go to RELEASE.
  - **RELEASE:** `direction`=0.
    - When all four debounced values are 0, go to WAIT.
    - New press events are ignored.
- **`move_count`:** 16-bit unsigned, wraps 0xFFFF→0x0000.
- **Held buttons:** a button held through WAIT never generates a command, because a command needs a new press edge.

## Timing
- **Reset values:** `direction`=0000, `move_count`=0, state WAIT, debounced values 0, counters 0.
- **Reset mid-operation:** reset in any state returns to the reset values on the next edge. A button still held after reset produces a press event (debounced value re-rises from 0) once it has been stable for DEBOUNCE_CYCLES.
- **Latency:** raw input rises before edge 0 and stays stable. Then:
  - synchronized value is 1 after edge 2;
  - debounced value is 1 after edge 2+DEBOUNCE_CYCLES;
  - `direction` is valid after edge 3+DEBOUNCE_CYCLES.
- **Clearing:** `direction` clears on the edge after the first cycle that samples `game_state`!=01. `move_count` updates on the same edge.
- **Bounce filtering:** a pulse or glitch shorter than DEBOUNCE_CYCLES cycles (measured after synchronization) never changes the debounced value.
- **game_state changes:** if `game_state` drops from 01 in the same cycle as a press event in WAIT, the press is discarded.

## Configuration
- **`DIR_REPEAT_EN` defined:**
  - In RELEASE, a repeat counter counts cycles while the debounced button for the latched code is still 1.
  - When the count reaches REPEAT_CYCLES and `game_state`==01, the block re-enters ISSUE with the same code and the counter clears.
  - Releasing that button, or `game_state`!=01, clears the counter.
- **Not defined:** no repeat counter exists. RELEASE always waits for full release. REPEAT_CYCLES is ignored.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
- **Reset:** `rst`=1 for 2 cycles with all buttons high → `direction`=0000, `move_count`=0. After release of `rst`, a command appears only once a button has been stable for 4 cycles.
- **Clean press:** `game_state`=01, `btn_left` rises and is held → `direction`=0100 after edge 7. Drive `game_state`=00 → `direction`=0000 on the next edge and `move_count`=1. Holding `btn_left` with `game_state` back at 01 issues no second command.
- **Bounce:** `btn_up` toggles high 3 cycles / low 2 cycles, repeated 10 times → `direction` stays 0000 and `move_count` stays 0.
- **Simultaneous press:** `btn_up` and `btn_right` rise in the same cycle → `direction`=0001.
- **Not playing:** `game_state`=11 and `btn_down` pressed → `direction` stays 0000. Then set `game_state`=01 with the button still held → still 0000. Release, wait 6 cycles, press again → `direction`=0010.
- **Auto-repeat (`DIR_REPEAT_EN` defined):** `btn_right` held and accepted → after 20 further held cycles in RELEASE with `game_state`=01, `direction`=1000 again, and `move_count` reaches 2 after the second accept.
